// File: rtl/byte_ram_responder.sv
// Byte-wide RAM target with session tracking and sticky protocol error capture.
// Optional saturating traffic counters are enabled with BYTE_RAM_STATS_EN.
module byte_ram_responder #(
    parameter int unsigned DEPTH = 4096,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RAMuse,
    input  logic [31:0] RAMaddr,
    input  logic        RAMread,
    input  logic        RAMwrite,
    input  logic [7:0]  data_to_RAM,
    output logic [7:0]  data_from_RAM,
    output logic        session_done,
    output logic [2:0]  last_len,
    output logic        error,
    output logic [2:0]  err_code
`ifdef BYTE_RAM_STATS_EN
    ,
    output logic [15:0] rd_bytes,
    output logic [15:0] wr_bytes,
    output logic [15:0] sessions
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state_q, state_d;
    logic [31:0] start_q, start_d;
    logic        dir_q, dir_d;
    logic [2:0]  count_q, count_d;
    logic        done_q, done_d;
    logic [2:0]  len_q, len_d;
    logic        err_q, err_d;
    logic [2:0]  code_q, code_d;
    logic [2:0]  fault;

    logic [7:0]    mem [DEPTH];
    logic [31:0]   offset;
    logic [AW-1:0] index;
    logic          in_range;
    logic          rd_ok;
    logic          wr_ok;

    // Offset compare covers both addresses below BASE and steps past the top,
    // including a 32-bit wrap, without ever folding back into the array.
    assign offset   = RAMaddr - BASE;
    assign in_range = ({1'b0, offset} < 33'(DEPTH));
    assign index    = offset[AW-1:0];
    assign rd_ok    = RAMuse & RAMread & ~RAMwrite & in_range;
    assign wr_ok    = RAMuse & RAMwrite & ~RAMread & in_range;

    assign data_from_RAM = rd_ok ? mem[index] : 8'h00;

    always_ff @(posedge clk) begin
        if (wr_ok && !reset) begin
            mem[index] <= data_to_RAM;
        end
    end

    // Lowest-numbered cause wins when several faults coincide.
    always_comb begin
        fault = 3'd0;
        if (RAMuse) begin
            if (!in_range) begin
                fault = 3'd1;
            end else if (RAMread && RAMwrite) begin
                fault = 3'd2;
            end else if (state_q == ACTIVE && RAMaddr != start_q + 32'(count_q)) begin
                fault = 3'd3;
            end else if (state_q == ACTIVE && count_q >= 3'd4) begin
                fault = 3'd4;
            end else if (state_q == ACTIVE && RAMwrite != dir_q) begin
                fault = 3'd5;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        dir_d   = dir_q;
        count_d = count_q;
        done_d  = 1'b0;
        len_d   = len_q;
        err_d   = err_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (RAMuse) begin
                    state_d = ACTIVE;
                    start_d = RAMaddr;
                    dir_d   = RAMwrite;
                    count_d = 3'd1;
                end
            end
            ACTIVE: begin
                if (RAMuse) begin
                    if (count_q != 3'd7) begin
                        count_d = count_q + 3'd1;
                    end
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    len_d   = count_q;
                    count_d = 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!err_q && fault != 3'd0) begin
            err_d  = 1'b1;
            code_d = fault;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= 32'h0;
            dir_q   <= 1'b0;
            count_q <= 3'd0;
            done_q  <= 1'b0;
            len_q   <= 3'd0;
            err_q   <= 1'b0;
            code_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            dir_q   <= dir_d;
            count_q <= count_d;
            done_q  <= done_d;
            len_q   <= len_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign session_done = done_q;
    assign last_len     = len_q;
    assign error        = err_q;
    assign err_code     = code_q;

`ifdef BYTE_RAM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q, ses_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q  <= 16'h0;
            wr_cnt_q  <= 16'h0;
            ses_cnt_q <= 16'h0;
        end else begin
            if (rd_ok && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'h1;
            if (wr_ok && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'h1;
            if (done_d && ses_cnt_q != 16'hFFFF) ses_cnt_q <= ses_cnt_q + 16'h1;
        end
    end

    assign rd_bytes = rd_cnt_q;
    assign wr_bytes = wr_cnt_q;
    assign sessions = ses_cnt_q;
`endif

endmodule

// File: doc/byte_ram_responder.md
BYTE_RAM_RESPONDER -- requirements
Module: byte_ram_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, meaning number of byte locations, power of two.
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, meaning byte address of location 0.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port RAMuse  input  1  initiator owns the bus this cycle.
REQ-006 SHALL have port RAMaddr  input  32  byte address.
REQ-007 SHALL have port RAMread  input  1  read strobe.
REQ-008 SHALL have port RAMwrite  input  1  write strobe.
REQ-009 SHALL have port data_to_RAM  input  8  write byte.
REQ-010 SHALL have port data_from_RAM  output  8  read byte.
REQ-011 SHALL have port session_done  output  1  one-cycle pulse at end of a RAMuse session.
REQ-012 SHALL have port last_len  output  3  byte count of the most recently completed session.
REQ-013 SHALL have port error  output  1  sticky protocol/range error flag.
REQ-014 SHALL have port err_code  output  3  first error cause: 1 range, 2 rd+wr, 3 non-sequential, 4 overlength, 5 direction change.

Function
REQ-015 SHALL treat an address as in range iff BASE <= RAMaddr < BASE+DEPTH; index = RAMaddr-BASE.
REQ-016 SHALL drive data_from_RAM combinationally as mem[index] when RAMuse & RAMread & ~RAMwrite & in range, else 8'h00 (zero-latency read, data valid before the same edge the initiator samples).
REQ-017 SHALL write data_to_RAM to mem[index] at the rising edge when RAMuse & RAMwrite & ~RAMread & in range & ~reset; out-of-range or rd+wr writes are dropped.
REQ-018 SHALL implement FSM IDLE/ACTIVE: IDLE->ACTIVE on edge with RAMuse=1 (latch start address, direction, count=1); ACTIVE stays while RAMuse=1 (count+1, count saturates at 7); ACTIVE->IDLE on edge with RAMuse=0.
REQ-019 SHALL pulse session_done for exactly one cycle following the ACTIVE->IDLE edge and load last_len with the session count in the same cycle.
REQ-020 SHALL in ACTIVE require RAMaddr == start + count (32-bit modulo), else error code 3.
REQ-021 SHALL flag code 4 when a session reaches a fifth byte, code 5 when the rd/wr direction differs from the latched one, code 2 when RAMread and RAMwrite are both high, code 1 on an out-of-range access; all checks apply only while RAMuse=1.
REQ-022 SHALL set error on the first detected fault and hold err_code of that first fault until reset; later faults do not overwrite it; simultaneous faults record the lowest code.
REQ-023 SHALL treat an address stepping past BASE+DEPTH-1 (including 32-bit wrap to 0) as out of range (code 1), not wrap into the array.
REQ-024 SHALL accept back-to-back sessions: RAMuse low for one cycle between sessions is sufficient.

Reset
REQ-025 SHALL on reset force FSM to IDLE, session_done=0, last_len=0, error=0, err_code=0, counters to 0; memory contents SHALL NOT be cleared.
REQ-026 SHALL on reset mid-session abandon the session without a session_done pulse and suppress any write at that edge.

Configuration
REQ-027 SHALL, when BYTE_RAM_STATS_EN is defined, add outputs rd_bytes[15:0], wr_bytes[15:0], sessions[15:0]: saturating counts of completed byte reads, byte writes, and session_done pulses.
REQ-028 SHALL, when BYTE_RAM_STATS_EN is undefined, omit those ports and counters with all other behaviour identical.

Verification
REQ-029 SHALL cover: 4-byte write session at 0x10 with bytes 0x44,0x33,0x22,0x11, then 4-byte read at 0x10 -> data_from_RAM 0x44,0x33,0x22,0x11 on successive cycles, last_len=4, two session_done pulses, error=0.
REQ-030 SHALL cover: read session at BASE+DEPTH-2 of 4 bytes -> first two bytes returned, third reads 8'h00, error=1, err_code=1.
REQ-031 SHALL cover: addresses 0x20,0x21,0x23 in one session -> err_code=3 at third byte; subsequent rd+wr fault leaves err_code=3.
REQ-032 SHALL cover: RAMuse held 5 cycles sequentially -> err_code=4, last_len=5.
REQ-033 SHALL cover: reset asserted on second byte of write session to 0x40 -> only mem[0x40] updated, no session_done, all outputs zero next cycle.
REQ-034 SHALL cover (BYTE_RAM_STATS_EN defined): three 4-byte reads, one 4-byte write -> rd_bytes=12, wr_bytes=4, sessions=4.
